fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle control for instruction fetch. It owns the word-addressed program counter and runs a request/acknowledge handshake to a variable-latency instruction memory. Fetched words are handed to decode over a valid/ready interface. Branch and jump resolution redirects the PC through a single redirect port. The block sits between the next-PC logic (branch/jump/jal selection) and decode, replacing a free-running per-clock PC update.

## Interface
Parameters:
- RESET_PC, 30'h0000_0000, word PC loaded on reset
- TIMEOUT, 16, maximum cycles waiting for imem_ack (used only with the timeout feature)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  32  byte address, always {pc, 2'b00}
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack
- redirect_valid  in  1  one-cycle pulse: next fetch from redirect_pc
- redirect_pc  in  30  word target (branch, jump, jr, jal)
- instr_valid  out  1  instr/instr_pc valid for decode
- instr_ready  in  1  decode accepts instr
- instr  out  32  fetched instruction
- instr_pc  out  30  word PC of instr
- pc_plus1  out  30  instr_pc + 1, for jal link and branch base
- fault  out  1  fetch timeout, sticky

## Operation
- States: IDLE, REQ, HOLD, FAULT. FAULT exists only with the timeout feature.
- IDLE: entered on reset and lasts one cycle. Then REQ.
- REQ:
  - imem_req=1, and imem_addr is stable.
  - When imem_ack is sampled high, latch imem_rdata and the current pc, then go to HOLD.
  - If a redirect arrives while in REQ, set flush_pend and load pc_next=redirect_pc. The request in flight is not withdrawn and its address does not change.
  - When that ack arrives with flush_pend set, discard the data, clear flush_pend, load pc from pc_next, and stay in REQ. imem_req stays high, so a new address goes out the next cycle.
- HOLD:
  - instr_valid=1.
  - If instr_ready is high and there is no redirect: pc <= pc+1, go to REQ.
  - If there is a redirect (with or without ready): pc <= redirect_pc, go to REQ. If instr_ready was also high, the transfer counts as accepted.
- The last redirect pulse wins. A second redirect in REQ overwrites pc_next.
- PC arithmetic is 30-bit modulo: 30'h3FFF_FFFF + 1 = 0.
- pc_plus1 is combinational from instr_pc, with the same wrap.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, imem_addr={RESET_PC,2'b00}
  - instr_valid=0, instr=0, instr_pc=0
  - flush_pend=0, fault=0
- Reset asserted mid-request:
  - imem_req drops immediately (asynchronously).
  - The memory must tolerate an abandoned request.
- imem_req first rises in cycle 1 after reset deassertion (cycle 0 is IDLE).
- Ack may come in the same cycle req is first high. Minimum latency is ack in cycle N, then instr_valid in cycle N+1.
- Peak throughput is one instruction per 2 cycles: HOLD and REQ alternate when ack is immediate and ready is held high.
- instr, instr_pc and instr_valid are registered outputs, stable while instr_valid && !instr_ready.
- instr_valid deasserts the cycle after a redirect in HOLD.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter runs while in REQ and clears on every ack.
  - When it reaches TIMEOUT with no ack, go to FAULT: imem_req=0, instr_valid=0, fault=1.
  - FAULT exits only on reset. Redirects are ignored in FAULT.
- Undefined:
  - No counter and no FAULT state.
  - fault is tied to 0, and REQ waits indefinitely.

## Structure
- Package fetch_pkg:
  - state enum (IDLE, REQ, HOLD, FAULT)
  - PC_W=30, INSTR_W=32
- Sub-module fetch_watchdog:
  - A TIMEOUT-cycle counter with clear/enable inputs and an expired output.
  - Instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- Reset release, RESET_PC=0, ack immediate, ready high → imem_addr sequence 0x0, 0x4, 0x8. instr_valid on alternate cycles; instr_pc 0, 1, 2.
- Ack after 3 wait cycles, then instr_ready low for 4 cycles → imem_addr held through the wait. instr and instr_pc stable while stalled. pc advances only after ready.
- Redirect to 30'h100 during HOLD with ready high → first instruction counted as accepted. Next imem_addr=0x400.
- Redirect to 30'h40 during REQ, ack 2 cycles later with data 0xDEADBEEF → no instr_valid for that data. Next imem_addr=0x100.
- pc=30'h3FFF_FFFF accepted → next imem_addr=0x0. pc_plus1 of the wrapped instruction = 0.
- With FETCH_TIMEOUT_EN and TIMEOUT=16, no ack → fault rises on the 16th REQ cycle and imem_req drops. A redirect is ignored. Only reset clears fault.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, state encoding and PC helper for the fetch sequencer
package fetch_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Word PC increment; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - ack timeout counter, built only when FETCH_TIMEOUT_EN is defined
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Expires during the TIMEOUT-th consecutive enabled cycle without a clear.
  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

  // Count enabled cycles; any clear restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and imem req/ack fetch FSM feeding decode; FETCH_TIMEOUT_EN adds watchdog and FAULT
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 30'h0000_0000,
  parameter int              TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               fault
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            flush_pend;

  assign imem_addr = {pc, 2'b00};
  assign pc_plus1  = pc_inc(instr_pc);

`ifdef FETCH_TIMEOUT_EN
  logic wd_expired;
  logic fault_q;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (imem_ack || (state != REQ)),
    .enable  (state == REQ),
    .expired (wd_expired)
  );

  assign fault = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign fault = 1'b0;
`endif

  // Fetch FSM: owns pc, the memory request and the registered decode-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_next     <= RESET_PC;
      flush_pend  <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
`ifdef FETCH_TIMEOUT_EN
      fault_q     <= 1'b0;
`endif
    end
`ifdef FETCH_TIMEOUT_EN
    else if (wd_expired) begin
      state       <= FAULT;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fault_q     <= 1'b1;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_pc;
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            if (flush_pend || redirect_valid) begin
              // Stale data from before a redirect: drop it and keep requesting.
              flush_pend <= 1'b0;
              pc         <= redirect_valid ? redirect_pc : pc_next;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end else if (redirect_valid) begin
            // The in-flight request keeps its address; retarget once it acks.
            flush_pend <= 1'b1;
            pc_next    <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end else if (instr_ready) begin
            pc          <= pc_inc(pc);
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        FAULT: begin
          state <= FAULT;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench: memory responder, decode monitor, directed fetch scenarios
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] instr;
    logic [29:0] pc;
    logic [29:0] plus1;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [29:0] instr_pc;
  logic [29:0] pc_plus1;
  logic        fault;

  int          checks;
  int          errors;
  int          lat;
  int          wcnt;
  logic        ovr_en;
  logic [31:0] addr_q[$];
  exp_t        instr_q[$];
  logic [5:0]  req_pat;
  logic [5:0]  val_pat;

  fetch_sequencer #(.RESET_PC(30'h0), .TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus1       (pc_plus1),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mkdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_instr(input logic [29:0] pc, input logic [29:0] plus1);
    exp_t e;
    e.instr = mkdata({pc, 2'b00});
    e.pc    = pc;
    e.plus1 = plus1;
    instr_q.push_back(e);
  endtask

  // Memory model: acks after lat waiting cycles and checks each acked address.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    wcnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (wcnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = ovr_en ? 32'hDEAD_BEEF : mkdata(imem_addr);
          wcnt       = 0;
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL imem_addr_unexpected got %h expected none", imem_addr);
          end else begin
            chk("imem_addr_at_ack", imem_addr, addr_q.pop_front());
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Decode monitor: every valid cycle must show the head entry; a handshake retires it.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && instr_valid) begin
        if (instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL instr_unexpected got %h pc %h expected none", instr, instr_pc);
        end else begin
          chk("instr", instr, instr_q[0].instr);
          chk("instr_pc", 32'(instr_pc), 32'(instr_q[0].pc));
          chk("pc_plus1", 32'(pc_plus1), 32'(instr_q[0].plus1));
          if (instr_ready) void'(instr_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    checks         = 0;
    errors         = 0;
    lat            = 0;
    ovr_en         = 1'b0;
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_pat        = 6'b101010;
    val_pat        = 6'b010100;

    next();
    smp();
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);

    // Back-to-back fetch from RESET_PC with immediate ack and ready high.
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    push_instr(30'd0, 30'd1);
    push_instr(30'd1, 30'd2);
    push_instr(30'd2, 30'd3);
    next();
    reset       = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next();
      if (c == 5) instr_ready = 1'b0;
      smp();
      chk($sformatf("req_pattern_c%0d", c), 32'(imem_req), 32'(req_pat[c]));
      chk($sformatf("valid_pattern_c%0d", c), 32'(instr_valid), 32'(val_pat[c]));
    end
    lat = 3;

    // Stall pc2 in HOLD, then a 3-wait fetch of pc3 and a 4-cycle decode stall.
    addr_q.push_back(32'hC);
    push_instr(30'd3, 30'd4);
    next(); smp();
    chk("stall_valid", 32'(instr_valid), 32'h1);
    next(); smp();
    next(); instr_ready = 1'b1; smp();
    for (int c = 9; c <= 12; c++) begin
      next();
      if (c == 12) instr_ready = 1'b0;
      smp();
      chk("wait_addr_held", imem_addr, 32'hC);
      chk("wait_req_high", 32'(imem_req), 32'h1);
    end
    for (int c = 13; c <= 16; c++) begin
      next(); smp();
      chk("hold_valid", 32'(instr_valid), 32'h1);
      chk("hold_req_low", 32'(imem_req), 32'h0);
      chk("hold_pc_not_advanced", imem_addr, 32'hC);
    end
    next(); instr_ready = 1'b1; smp();
    lat = 0;

    // Redirect in HOLD with ready high, then a redirect during a waiting REQ.
    addr_q.push_back(32'h10);
    push_instr(30'd4, 30'd5);
    addr_q.push_back(32'h400);
    next(); smp();
    next(); redirect_valid = 1'b1; redirect_pc = 30'h100; smp();
    lat    = 3;
    ovr_en = 1'b1;
    next(); redirect_valid = 1'b0; smp();
    chk("valid_drop_after_redirect", 32'(instr_valid), 32'h0);
    chk("redirect_hold_addr", imem_addr, 32'h400);
    next(); redirect_valid = 1'b1; redirect_pc = 30'h40; smp();
    chk("inflight_addr_held_a", imem_addr, 32'h400);
    next(); redirect_valid = 1'b0; smp();
    chk("inflight_addr_held_b", imem_addr, 32'h400);
    next(); smp();
    ovr_en = 1'b0;
    lat    = 0;
    addr_q.push_back(32'h100);
    push_instr(30'h40, 30'h41);
    next(); smp();
    chk("flush_next_addr", imem_addr, 32'h100);
    chk("flush_no_valid", 32'(instr_valid), 32'h0);
    chk("flush_req_high", 32'(imem_req), 32'h1);

    // PC wrap at the top of the word address space.
    next(); redirect_valid = 1'b1; redirect_pc = 30'h3FFF_FFFF; smp();
    addr_q.push_back(32'hFFFF_FFFC);
    push_instr(30'h3FFF_FFFF, 30'h0);
    addr_q.push_back(32'h0);
    push_instr(30'h0, 30'h1);
    next(); redirect_valid = 1'b0; smp();
    chk("wrap_valid_drop", 32'(instr_valid), 32'h0);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    next(); smp();
    chk("wrap_pc_plus1", 32'(pc_plus1), 32'h0);
    next(); smp();
    chk("wrap_next_addr", imem_addr, 32'h0);
    next(); instr_ready = 1'b0; smp();
    chk("wrap_hold_valid", 32'(instr_valid), 32'h1);
    next(); smp();
    next(); smp();
    chk("addr_q_drained", 32'(addr_q.size()), 32'h0);
    chk("instr_q_one_left", 32'(instr_q.size()), 32'h1);

    // Asynchronous reset while a request is outstanding.
    lat = 255;
    next(); instr_ready = 1'b1; smp();
    next(); smp();
    chk("pre_reset_req", 32'(imem_req), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_req", 32'(imem_req), 32'h0);
    chk("async_reset_valid", 32'(instr_valid), 32'h0);
    chk("async_reset_addr", imem_addr, 32'h0);
    chk("instr_q_drained", 32'(instr_q.size()), 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: no ack ever; fault after 16 REQ cycles, sticky until reset.
    instr_ready = 1'b0;
    next();
    reset = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) next();
      smp();
      if (c == 16) chk("fault_before_expire", 32'(fault), 32'h0);
      if (c == 17) begin
        chk("fault_set", 32'(fault), 32'h1);
        chk("fault_req_low", 32'(imem_req), 32'h0);
      end
    end
    next(); redirect_valid = 1'b1; redirect_pc = 30'h55; smp();
    next(); redirect_valid = 1'b0; smp();
    chk("fault_sticky", 32'(fault), 32'h1);
    chk("fault_ignores_redirect_req", 32'(imem_req), 32'h0);
    chk("fault_ignores_redirect_addr", imem_addr, 32'h0);
    next();
    reset = 1'b1;
    smp();
    chk("fault_cleared_by_reset", 32'(fault), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
